// File: rtl/sec_decoder_awe_param.sv
// Single-error-correcting AN-code decoder.
// Accepts a received codeword W = A*N +/- 2^i, finds the single-bit arithmetic
// error (if any) by residue matching, corrects it, and divides by A to recover N.
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst       - asynchronous active-high reset
//   start     - decode request, accepted only while idle
//   w_in      - received codeword, captured on the accepting edge
//   busy      - high from the accepting edge until the DONE cycle ends
//   done      - one-cycle pulse when results become valid
//   n_out     - decoded data word
//   status    - 0 clean, 1 corrected, 2 uncorrectable
//   err_pos   - corrected bit position
//   err_sign  - 1 when the error was +2^i (fixed by subtracting)
module sec_decoder_awe_param #(
  parameter int unsigned DATA_BITS = 30,
  parameter int unsigned W_BITS    = 38,
  parameter int unsigned A         = 233
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [W_BITS-1:0]           w_in,
  output logic                        busy,
  output logic                        done,
  output logic [DATA_BITS-1:0]        n_out,
  output logic [1:0]                  status,
  output logic [$clog2(W_BITS)-1:0]   err_pos,
  output logic                        err_sign
);

  // A < 2^AW, so residues and division remainders fit in AW bits
  localparam int unsigned AW = W_BITS - DATA_BITS;
  localparam int unsigned PW = $clog2(W_BITS);
  localparam int unsigned CW = $clog2(W_BITS + 1);

  localparam logic [1:0] ST_CLEAN = 2'd0;
  localparam logic [1:0] ST_CORR  = 2'd1;
  localparam logic [1:0] ST_UNCOR = 2'd2;

  typedef enum logic [2:0] {IDLE, RES, SEARCH, DIV, DONE} state_t;

  state_t            state;
  logic [W_BITS-1:0] w_reg;
  logic [AW-1:0]     r;
  logic [AW-1:0]     p;
  logic [PW-1:0]     idx;
  logic [W_BITS-1:0] dq;        // dividend shifts out MSB-first, quotient shifts in
  logic [AW-1:0]     rem;
  logic [CW-1:0]     cnt;
  logic              fixed;
  logic [PW-1:0]     fix_pos;
  logic              fix_sign;

  // Candidate arithmetic carried at W_BITS+1 bits so plus-overflow is visible
  logic [W_BITS:0]   pow_c;
  logic [W_BITS:0]   w_ext;
  logic [W_BITS:0]   plus_c;
  logic [W_BITS-1:0] minus_c;
  logic              minus_ok;
  logic              plus_ok;
  logic [AW:0]       rp_sum;
  logic [AW:0]       p_dbl;
  logic [AW-1:0]     p_nx;
  logic [AW:0]       rem_sh;
  logic              div_ge;
  logic [AW-1:0]     rem_nx;
  logic [W_BITS-1:0] q_nx;
  logic              q_ovf;
  logic [AW-1:0]     res_c;

  assign pow_c    = (W_BITS + 1)'(1) << idx;
  assign w_ext    = {1'b0, w_reg};
  assign plus_c   = w_ext + pow_c;
  assign minus_c  = w_reg - pow_c[W_BITS-1:0];
  assign minus_ok = (w_ext >= pow_c) && (r == p);
  // r and p are both in 1..A-1, so (r+p) mod A == 0 exactly when r+p == A
  assign rp_sum   = {1'b0, r} + {1'b0, p};
  assign plus_ok  = !plus_c[W_BITS] && (rp_sum == (AW + 1)'(A));

  // Next power-of-two residue: 2p < 2A, so one conditional subtract suffices
  assign p_dbl = {p, 1'b0};
  assign p_nx  = (p_dbl >= (AW + 1)'(A)) ? AW'(p_dbl - (AW + 1)'(A)) : AW'(p_dbl);

  // One restoring-division step
  assign rem_sh = {rem, dq[W_BITS-1]};
  assign div_ge = rem_sh >= (AW + 1)'(A);
  assign rem_nx = div_ge ? AW'(rem_sh - (AW + 1)'(A)) : AW'(rem_sh);
  assign q_nx   = {dq[W_BITS-2:0], div_ge};
  assign q_ovf  = |q_nx[W_BITS-1:DATA_BITS];

  assign res_c = AW'(w_reg % W_BITS'(A));

  // Decoder FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      w_reg    <= '0;
      r        <= '0;
      p        <= '0;
      idx      <= '0;
      dq       <= '0;
      rem      <= '0;
      cnt      <= '0;
      fixed    <= 1'b0;
      fix_pos  <= '0;
      fix_sign <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      n_out    <= '0;
      status   <= ST_CLEAN;
      err_pos  <= '0;
      err_sign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            w_reg <= w_in;
            busy  <= 1'b1;
            state <= RES;
          end
        end
        RES: begin
          r        <= res_c;
          fixed    <= 1'b0;
          fix_pos  <= '0;
          fix_sign <= 1'b0;
          dq       <= w_reg;
          rem      <= '0;
          cnt      <= '0;
          idx      <= '0;
          p        <= AW'(1);
          state    <= (res_c == '0) ? DIV : SEARCH;
        end
        SEARCH: begin
          // Minus candidate takes priority over plus at the same position
          if (minus_ok) begin
            dq       <= minus_c;
            fixed    <= 1'b1;
            fix_pos  <= idx;
            fix_sign <= 1'b1;
            state    <= DIV;
          end else if (plus_ok) begin
            dq       <= plus_c[W_BITS-1:0];
            fixed    <= 1'b1;
            fix_pos  <= idx;
            fix_sign <= 1'b0;
            state    <= DIV;
          end else if (idx == PW'(W_BITS - 1)) begin
            n_out    <= '0;
            status   <= ST_UNCOR;
            err_pos  <= '0;
            err_sign <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            idx <= PW'(idx + 1'b1);
            p   <= p_nx;
          end
        end
        DIV: begin
          dq  <= q_nx;
          rem <= rem_nx;
          cnt <= CW'(cnt + 1'b1);
          if (cnt == CW'(W_BITS - 1)) begin
            done  <= 1'b1;
            state <= DONE;
            if (q_ovf) begin
              n_out    <= '0;
              status   <= ST_UNCOR;
              err_pos  <= '0;
              err_sign <= 1'b0;
            end else begin
              n_out    <= q_nx[DATA_BITS-1:0];
              status   <= fixed ? ST_CORR : ST_CLEAN;
              err_pos  <= fixed ? fix_pos : '0;
              err_sign <= fixed & fix_sign;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sec_decoder_awe_param.sv
// Self-checking bench for sec_decoder_awe_param: directed vectors plus random
// single-error sweeps compared against an arithmetic reference model.
module tb_sec_decoder_awe_param;

  localparam int unsigned DATA_BITS = 30;
  localparam int unsigned W_BITS    = 38;
  localparam int unsigned A         = 233;
  localparam longint unsigned AL    = 64'd233;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [W_BITS-1:0]    w_in = '0;
  logic                 busy;
  logic                 done;
  logic [DATA_BITS-1:0] n_out;
  logic [1:0]           status;
  logic [5:0]           err_pos;
  logic                 err_sign;

  int total_cnt = 0;
  int pass_cnt  = 0;

  sec_decoder_awe_param #(.DATA_BITS(DATA_BITS), .W_BITS(W_BITS), .A(A)) dut (
    .clk(clk), .rst(rst), .start(start), .w_in(w_in), .busy(busy), .done(done),
    .n_out(n_out), .status(status), .err_pos(err_pos), .err_sign(err_sign)
  );

  always #5 clk = ~clk;

  // Reference: residue search by the decoding rules, then plain division
  function automatic void model(input longint unsigned w, output longint unsigned n,
                                output int st, output int pos, output int sg, output int lat);
    longint unsigned r, p, c, q, lim, pw;
    bit found;
    lim = 64'd1 << W_BITS;
    r = w % AL;
    st = 0; pos = 0; sg = 0; n = 0; found = 0; c = w;
    lat = W_BITS + 1;
    if (r != 0) begin
      for (int i = 0; i < W_BITS && !found; i++) begin
        pw = 64'd1 << i;
        p = pw % AL;
        if (w >= pw && r == p) begin
          c = w - pw; found = 1; pos = i; sg = 1; lat = W_BITS + i + 2;
        end else if (w + pw < lim && (r + p) % AL == 0) begin
          c = w + pw; found = 1; pos = i; sg = 0; lat = W_BITS + i + 2;
        end
      end
      if (!found) begin
        st = 2; pos = 0; sg = 0;
        return;
      end
    end
    q = c / AL;
    if (q >= (64'd1 << DATA_BITS)) begin
      st = 2; n = 0; pos = 0; sg = 0;
    end else begin
      n = q; st = found ? 1 : 0;
    end
  endfunction

  // Launch one decode, count edges to done, then return to idle
  task automatic decode(input logic [W_BITS-1:0] w, output logic [DATA_BITS-1:0] n,
                        output logic [1:0] st, output logic [5:0] pos, output logic sg,
                        output int lat, output logic bsy);
    @(negedge clk);
    start = 1'b1;
    w_in  = w;
    @(posedge clk);
    #1;
    start = 1'b0;
    w_in  = W_BITS'({$urandom, $urandom});
    bsy   = busy;
    lat   = 0;
    while (done !== 1'b1 && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n = n_out; st = status; pos = err_pos; sg = err_sign;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, done, n_out, status, err_pos, err_sign} !== '0)
      $display("FAIL reset_outputs: got busy=%0b done=%0b n=%0d st=%0d pos=%0d sg=%0b required all 0",
               busy, done, n_out, status, err_pos, err_sign);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vector(input string name, input logic [W_BITS-1:0] w,
                             input longint unsigned en, input int est, input int epos,
                             input int esg, input int elat);
    logic [DATA_BITS-1:0] n; logic [1:0] st; logic [5:0] pos; logic sg; int lat; logic bsy;
    decode(w, n, st, pos, sg, lat, bsy);
    total_cnt++;
    if (bsy !== 1'b1) $display("FAIL %s_busy: got %0b required 1", name, bsy); else pass_cnt++;
    total_cnt++;
    if (lat != elat) $display("FAIL %s_latency: got %0d required %0d", name, lat, elat); else pass_cnt++;
    total_cnt++;
    if (64'(n) != en) $display("FAIL %s_n: got %0d required %0d", name, n, en); else pass_cnt++;
    total_cnt++;
    if (int'(st) != est) $display("FAIL %s_status: got %0d required %0d", name, st, est); else pass_cnt++;
    total_cnt++;
    if (int'(pos) != epos || int'(sg) != esg)
      $display("FAIL %s_err: got pos=%0d sign=%0b required pos=%0d sign=%0d", name, pos, sg, epos, esg);
    else pass_cnt++;
    // Results hold after done while idle
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (64'(n_out) != en || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL %s_hold: got n=%0d busy=%0b done=%0b required n=%0d busy=0 done=0",
               name, n_out, busy, done, en);
    else pass_cnt++;
  endtask

  task automatic test_clean();
    test_vector("clean", 38'd250181844759, 64'd1073741823, 0, 0, 0, 39);
  endtask

  task automatic test_single_error();
    test_vector("single_err", 38'd250181844791, 64'd1073741823, 1, 5, 1, 45);
  endtask

  task automatic test_overflow();
    test_vector("q_overflow", 38'd250181844992, 64'd0, 2, 0, 0, 39);
  endtask

  // Random single-error words at every position and sign, plus a few double errors
  task automatic test_random_sweep();
    logic [DATA_BITS-1:0] n; logic [1:0] st; logic [5:0] pos; logic sg; int lat; logic bsy;
    longint unsigned nn, w, en; int est, epos, esg, elat;
    for (int i = 0; i < W_BITS; i++) begin
      for (int s = 0; s < 2; s++) begin
        nn = 64'($urandom) & ((64'd1 << DATA_BITS) - 1);
        if (s == 1) begin
          for (int t = 0; t < 40 && AL * nn + (64'd1 << i) >= (64'd1 << W_BITS); t++) nn = nn >> 1;
          w = AL * nn + (64'd1 << i);
        end else begin
          if (AL * nn < (64'd1 << i)) nn = nn | (64'd3 << 28);
          w = AL * nn - (64'd1 << i);
        end
        model(w, en, est, epos, esg, elat);
        decode(W_BITS'(w), n, st, pos, sg, lat, bsy);
        total_cnt++;
        if (int'(st) != est || 64'(n) != en)
          $display("FAIL sweep_result i=%0d s=%0d: got st=%0d n=%0d required st=%0d n=%0d",
                   i, s, st, n, est, en);
        else pass_cnt++;
        total_cnt++;
        if (int'(pos) != epos || int'(sg) != esg)
          $display("FAIL sweep_err i=%0d s=%0d: got pos=%0d sign=%0b required pos=%0d sign=%0d",
                   i, s, pos, sg, epos, esg);
        else pass_cnt++;
        total_cnt++;
        if (lat != elat)
          $display("FAIL sweep_latency i=%0d s=%0d: got %0d required %0d", i, s, lat, elat);
        else pass_cnt++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      nn = 64'($urandom_range(1, 4000000));
      w  = AL * nn + (64'd1 << $urandom_range(0, 20)) + (64'd1 << $urandom_range(21, 35));
      model(w, en, est, epos, esg, elat);
      decode(W_BITS'(w), n, st, pos, sg, lat, bsy);
      total_cnt++;
      if (int'(st) != est || 64'(n) != en || int'(pos) != epos || int'(sg) != esg || lat != elat)
        $display("FAIL double_err k=%0d: got st=%0d n=%0d pos=%0d sg=%0b lat=%0d required st=%0d n=%0d pos=%0d sg=%0d lat=%0d",
                 k, st, n, pos, sg, lat, est, en, epos, esg, elat);
      else pass_cnt++;
    end
  endtask

  // start held high while w_in changes every cycle
  task automatic test_back_to_back();
    localparam int HOLD = 60;
    localparam int OBS  = 170;
    logic [W_BITS-1:0]    words [HOLD];
    logic                 obs_done [OBS];
    logic [DATA_BITS-1:0] obs_n [OBS];
    logic [1:0]           obs_st [OBS];
    logic [5:0]           obs_pos [OBS];
    logic                 obs_sg [OBS];
    bit                   exp_done [OBS];
    longint unsigned      exp_n [OBS];
    int exp_st [OBS]; int exp_pos [OBS]; int exp_sg [OBS];
    longint unsigned en; int est, epos, esg, elat, acc, de;
    for (int c = 0; c < HOLD; c++) begin
      words[c] = W_BITS'(AL * 64'($urandom_range(0, 1 << 29)));
      if ($urandom_range(0, 1) == 1) words[c] = words[c] + W_BITS'(64'd1 << $urandom_range(0, 12));
    end
    for (int c = 0; c < OBS; c++) exp_done[c] = 0;
    // Accept at edge a, done at a+lat, idle again so next accept at a+lat+2
    acc = 0;
    while (acc < HOLD) begin
      model(64'(words[acc]), en, est, epos, esg, elat);
      de = acc + elat;
      exp_done[de] = 1; exp_n[de] = en; exp_st[de] = est; exp_pos[de] = epos; exp_sg[de] = esg;
      acc = de + 2;
    end
    for (int c = 0; c < OBS; c++) begin
      @(negedge clk);
      start = (c < HOLD);
      w_in  = (c < HOLD) ? words[c] : W_BITS'({$urandom, $urandom});
      @(posedge clk);
      #1;
      obs_done[c] = done; obs_n[c] = n_out; obs_st[c] = status;
      obs_pos[c] = err_pos; obs_sg[c] = err_sign;
    end
    start = 1'b0;
    for (int c = 0; c < OBS; c++) begin
      total_cnt++;
      if (obs_done[c] !== exp_done[c])
        $display("FAIL b2b_done edge=%0d: got %0b required %0b", c, obs_done[c], exp_done[c]);
      else pass_cnt++;
      if (exp_done[c]) begin
        total_cnt++;
        if (64'(obs_n[c]) != exp_n[c] || int'(obs_st[c]) != exp_st[c] ||
            int'(obs_pos[c]) != exp_pos[c] || int'(obs_sg[c]) != exp_sg[c])
          $display("FAIL b2b_result edge=%0d: got n=%0d st=%0d pos=%0d sg=%0b required n=%0d st=%0d pos=%0d sg=%0d",
                   c, obs_n[c], obs_st[c], obs_pos[c], obs_sg[c], exp_n[c], exp_st[c], exp_pos[c], exp_sg[c]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL b2b_idle: got busy=%0b required 0", busy); else pass_cnt++;
  endtask

  // Reset asserted mid-division aborts the decode
  task automatic test_reset_mid_div();
    int seen;
    @(negedge clk);
    start = 1'b1;
    w_in  = 38'd250181844759;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, done, n_out, status, err_pos, err_sign} !== '0)
      $display("FAIL rst_mid_div: got busy=%0b done=%0b n=%0d st=%0d pos=%0d sg=%0b required all 0",
               busy, done, n_out, status, err_pos, err_sign);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    total_cnt++;
    if (seen != 0) $display("FAIL rst_no_done: got %0d done pulses required 0", seen); else pass_cnt++;
    test_vector("after_rst", 38'd250181844759, 64'd1073741823, 0, 0, 0, 39);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_overflow();
    test_random_sweep();
    test_back_to_back();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
